// File: rtl/blinky_pkg.sv
// Shared types and defaults for the blinker's push-button front end.
// Default tick counts assume a 100 MHz clock (2.5 ms debounce, 250 ms long press).
package blinky_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } t_btn_state;

  localparam int c_default_debounce_ticks   = 250000;
  localparam int c_default_long_press_ticks = 25000000;

endpackage

// File: rtl/button_control_if.sv
// Button pin and blinker control lines between the board side (master) and button_control (slave).
interface button_control_if;

  logic i_button;
  logic o_enable;
  logic o_speed;
  logic o_press_pulse;
  logic o_long_pulse;

  modport master (
    output i_button,
    input  o_enable,
    input  o_speed,
    input  o_press_pulse,
    input  o_long_pulse
  );

  modport slave (
    input  i_button,
    output o_enable,
    output o_speed,
    output o_press_pulse,
    output o_long_pulse
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer: a new level is accepted
// only after the synchronized input has differed from it for c_debounce_ticks cycles.
module button_debounce
  import blinky_pkg::*;
#(
  parameter int c_debounce_ticks = c_default_debounce_ticks
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int c_cnt_w = (c_debounce_ticks > 1) ? $clog2(c_debounce_ticks) : 1;
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(c_debounce_ticks - 1);

  logic               sync1;
  logic               sync2;
  logic [c_cnt_w-1:0] deb_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_cnt <= '0;
      o_level <= 1'b0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
      // Any return to the accepted level restarts the hold window.
      if (sync2 == o_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == c_deb_last) begin
        o_level <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_control.sv
// Turns a raw push-button into blinker controls: short press toggles o_enable,
// long press toggles o_speed, each with a one-cycle event strobe.
module button_control
  import blinky_pkg::*;
#(
  parameter int c_debounce_ticks   = c_default_debounce_ticks,
  parameter int c_long_press_ticks = c_default_long_press_ticks
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  button_control_if.slave  bus
);

  localparam int c_hold_w = (c_long_press_ticks > 1) ? $clog2(c_long_press_ticks) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(c_long_press_ticks - 1);

  logic                level;
  t_btn_state          state;
  logic [c_hold_w-1:0] hold_cnt;
  logic                enable;
  logic                speed;
  logic                press_pulse;
  logic                long_pulse;

  button_debounce #(
    .c_debounce_ticks (c_debounce_ticks)
  ) u_debounce (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_raw     (bus.i_button),
    .o_level   (level)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      enable      <= 1'b0;
      speed       <= 1'b0;
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (level) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          // Release is tested first so a release on the threshold cycle stays a short press.
          if (!level) begin
            state       <= IDLE;
            press_pulse <= 1'b1;
            enable      <= ~enable;
          end else if (hold_cnt == c_hold_last) begin
            state      <= LONG;
            long_pulse <= 1'b1;
            speed      <= ~speed;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (!level) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_enable      = enable;
  assign bus.o_speed       = speed;
  assign bus.o_press_pulse = press_pulse;
  assign bus.o_long_pulse  = long_pulse;

endmodule

// File: tb/tb_button_control.sv
// Bench for button_control: table of press lengths plus reset and bounce sequences,
// with expected pulse events queued at stimulus time and matched as pulses appear.
module tb_button_control;

  localparam int c_deb  = 4;
  localparam int c_long = 20;

  typedef struct {
    int cyc;
    bit is_long;
    bit en;
    bit spd;
  } ev_t;

  typedef struct {
    int n_high;
    bit exp_press;
    bit exp_long;
  } vec_t;

  logic i_clock   = 1'b0;
  logic i_reset_n = 1'b1;

  button_control_if bus ();

  button_control #(
    .c_debounce_ticks   (c_deb),
    .c_long_press_ticks (c_long)
  ) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus.slave)
  );

  always #5 i_clock = ~i_clock;

  int  cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  ev_t sb[$];
  ev_t mon_ev;
  int  checks = 0;
  int  fails  = 0;
  bit  exp_en  = 1'b0;
  bit  exp_spd = 1'b0;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input bit lng);
    ev_t ev;
    if (lng) exp_spd = ~exp_spd;
    else     exp_en  = ~exp_en;
    ev.cyc     = c;
    ev.is_long = lng;
    ev.en      = exp_en;
    ev.spd     = exp_spd;
    sb.push_back(ev);
  endtask

  // Raw edge lands before edge k = cyc+1; release lands before edge k+n.
  task automatic press(input int n, input bit exp_press, input bit exp_long);
    int k;
    k = cyc + 1;
    if (exp_long)       expect_ev(k + 2 + c_deb + c_long, 1'b1);
    else if (exp_press) expect_ev(k + n + 2 + c_deb, 1'b0);
    bus.i_button = 1'b1;
    tick(n);
    bus.i_button = 1'b0;
    tick(c_deb + c_long);
    check("sb_drained", sb.size(), 0);
    check("enable_level", bus.o_enable, exp_en);
    check("speed_level", bus.o_speed, exp_spd);
  endtask

  always @(negedge i_clock) begin
    if (bus.o_press_pulse === 1'b1 || bus.o_long_pulse === 1'b1) begin
      check("pulse_exclusive", bus.o_press_pulse & bus.o_long_pulse, 0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: press=%0b long=%0b at cycle %0d, required none",
                 bus.o_press_pulse, bus.o_long_pulse, cyc);
      end else begin
        mon_ev = sb.pop_front();
        check("pulse_cycle", cyc, mon_ev.cyc);
        check("pulse_kind_long", bus.o_long_pulse, mon_ev.is_long);
        check("pulse_enable", bus.o_enable, mon_ev.en);
        check("pulse_speed", bus.o_speed, mon_ev.spd);
      end
    end
  end

  initial begin
    int k;
    vecs[0] = '{n_high: 3,  exp_press: 1'b0, exp_long: 1'b0};
    vecs[1] = '{n_high: 10, exp_press: 1'b1, exp_long: 1'b0};
    vecs[2] = '{n_high: 10, exp_press: 1'b1, exp_long: 1'b0};
    vecs[3] = '{n_high: 4,  exp_press: 1'b1, exp_long: 1'b0};
    vecs[4] = '{n_high: 20, exp_press: 1'b1, exp_long: 1'b0};
    vecs[5] = '{n_high: 21, exp_press: 1'b0, exp_long: 1'b1};
    vecs[6] = '{n_high: 40, exp_press: 1'b0, exp_long: 1'b1};
    vecs[7] = '{n_high: 21, exp_press: 1'b0, exp_long: 1'b1};
    vecs[8] = '{n_high: 10, exp_press: 1'b1, exp_long: 1'b0};

    // Reset with the button held, then release reset.
    bus.i_button = 1'b0;
    #2;
    i_reset_n    = 1'b0;
    bus.i_button = 1'b1;
    tick(3);
    check("reset_outputs", {bus.o_enable, bus.o_speed, bus.o_press_pulse, bus.o_long_pulse}, 0);
    i_reset_n = 1'b1;
    k = cyc + 1;
    expect_ev(k + 10 + 2 + c_deb, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("post_reset_quiet", {bus.o_press_pulse, bus.o_long_pulse}, 0);
    end
    tick(4);
    bus.i_button = 1'b0;
    tick(15);
    check("held_through_reset_drained", sb.size(), 0);
    check("held_through_reset_enable", bus.o_enable, 1);

    // Press-length table.
    for (int i = 0; i < 9; i++) begin
      press(vecs[i].n_high, vecs[i].exp_press, vecs[i].exp_long);
    end

    // Bounce then a clean hold.
    for (int i = 0; i < 8; i++) begin
      bus.i_button = (i % 2 == 0);
      tick(1);
    end
    press(10, 1'b1, 1'b0);

    // Reset at hold cycle 10 of a long press, button released just after reset.
    check("pre_reset_enable", bus.o_enable, 1);
    check("pre_reset_speed", bus.o_speed, 1);
    bus.i_button = 1'b1;
    tick(13 + c_deb);
    i_reset_n = 1'b0;
    #1;
    check("mid_reset_outputs", {bus.o_enable, bus.o_speed, bus.o_press_pulse, bus.o_long_pulse}, 0);
    exp_en  = 1'b0;
    exp_spd = 1'b0;
    sb.delete();
    tick(2);
    i_reset_n = 1'b1;
    tick(1);
    bus.i_button = 1'b0;
    tick(30);
    check("mid_reset_no_pulse", sb.size(), 0);
    check("mid_reset_final", {bus.o_enable, bus.o_speed}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/button_control.md
Name: button_control

Overview:
- Input-side companion to the LED blinker: turns one raw, bouncy, asynchronous push-button into the blinker's control signals.
- A short press toggles o_enable. A long press toggles o_speed.
- One-cycle event pulses are also provided for other consumers.
- Sits between the board button pin and the blinker's i_enable/i_speed inputs, in the same clock domain.

Parameters:
- c_debounce_ticks, 250000, consecutive cycles a synchronized level must hold before it is accepted; must be >= 2.
- c_long_press_ticks, 25000000, cycles a debounced press must last to count as long; must be >= 2.

Ports:
- i_clock  input  1  system clock; all state on rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_button  input  1  raw button level, active-high, asynchronous to i_clock.
- o_enable  output  1  toggled by each short press; drives blinker i_enable.
- o_speed  output  1  toggled by each long press; drives blinker i_speed.
- o_press_pulse  output  1  one-cycle strobe when a short press completes.
- o_long_pulse  output  1  one-cycle strobe when a press becomes long.

Behaviour:
- Reset:
  - The design has one clock, i_clock, and one reset, i_reset_n. Reset is asynchronous and active-low.
  - While i_reset_n=0: synchronizer flops=0, debounced level=0, counters=0, state=IDLE, all outputs=0.
  - Reset takes effect immediately. No pulse is emitted on entry to or exit from reset.
- Synchronizer: two flops on i_button, giving sync2. A raw change before edge k is visible on sync2 after edge k+1.
- Debounce:
  - deb_cnt resets to 0 whenever sync2 == debounced level.
  - Otherwise deb_cnt increments each cycle.
  - When deb_cnt == c_debounce_ticks-1 and sync2 still differs, the debounced level takes sync2 and deb_cnt returns to 0.
  - A clean raw edge before edge k therefore appears on the debounced level after edge k+1+c_debounce_ticks.
  - Any excursion shorter than c_debounce_ticks cycles is discarded.
- FSM (states IDLE, PRESSED, LONG; registered; samples the debounced level):
  - IDLE: on debounced level=1, go to PRESSED with hold_cnt=0.
  - PRESSED, debounced level=0: go to IDLE. For the next cycle, o_press_pulse=1 and o_enable inverts.
  - PRESSED, hold_cnt == c_long_press_ticks-1 while still pressed: go to LONG. For the next cycle, o_long_pulse=1 and o_speed inverts.
  - PRESSED, otherwise: hold_cnt increments.
  - If release and the long threshold occur in the same cycle, release wins: short press, no long pulse.
  - LONG: on debounced level=0, go to IDLE with no pulse. While held, stay in LONG; o_long_pulse is not repeated.
- Pulses are registered outputs, high for exactly one cycle. o_press_pulse and o_long_pulse are never high together.
- Output latency:
  - o_press_pulse is high in the cycle after edge k+2+c_debounce_ticks, where k is the clean raw release edge.
  - o_long_pulse is high c_long_press_ticks cycles after PRESSED is entered.
- Button held through reset release: the debounced level starts at 0, so the held button is accepted as a new press after debounce.
- Reset mid-press: state returns to IDLE and outputs clear. A later release produces no pulse.
- Widths:
  - deb_cnt is $clog2(c_debounce_ticks) bits.
  - hold_cnt is $clog2(c_long_press_ticks) bits.
  - Counters never wrap: they are cleared or saturate by the rules above.

Decomposition:
- Shared package blinky_pkg holds:
  - state enum t_btn_state {IDLE, PRESSED, LONG};
  - constants c_default_debounce_ticks=250000 and c_default_long_press_ticks=25000000.
- One sub-module, button_debounce, contains the synchronizer, deb_cnt and the debounced level. It is parameterized by c_debounce_ticks, has ports i_clock, i_reset_n, i_raw and o_level, and is instantiated once.

Test Plan:
All scenarios use bench parameters c_debounce_ticks=4 and c_long_press_ticks=20.
1. Reset: hold i_reset_n=0 with i_button=1, then release -> all outputs 0 during reset, and no pulse for at least 6 cycles after release.
2. Glitch: drive i_button=1 for 3 cycles, then 0 -> no pulse; o_enable and o_speed stay 0.
3. Short press: drive 1 for 10 cycles, then 0 at edge k -> one o_press_pulse in the cycle after edge k+6; o_enable goes 0 to 1. A repeated press returns o_enable to 0.
4. Long press: drive 1 for 40 cycles -> one o_long_pulse exactly 20 cycles after PRESSED is entered; o_speed goes 0 to 1. Release produces no o_press_pulse.
5. Bounce: toggle i_button every cycle for 8 cycles, then hold 1 for 10 cycles, then 0 -> exactly one o_press_pulse.
6. Reset mid long press: assert i_reset_n=0 at hold cycle 10, deassert, then release the button -> outputs 0 and no pulse on release.
